// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART types and the parity helper used by TX and RX.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int c_MAX_DATA_WIDTH = 9;

    // Caller zero-extends narrower payloads; zeros do not change the XOR.
    function automatic logic calc_parity(input logic [c_MAX_DATA_WIDTH-1:0] data,
                                         input logic                        odd);
        return (^data) ^ odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : synchronous FIFO with occupancy count and wrap-bit pointers.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = (c_AW+1)'(1);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
    end

    // The extra MSB distinguishes full (lap ahead) from empty (same lap).
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign count   = r_wr_ptr - r_rd_ptr;
    assign rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/uart_tx_gen.sv
// ============================================================================
// uart_tx_gen : FIFO-fed UART transmitter with runtime prescaler and framing.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         p_data,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic                          par_en,
    input  logic                          par_type,
    input  logic                          stop2,
    input  logic [PRESC_WIDTH-1:0]        prescale,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                     c_BIT_W    = $clog2(DATA_WIDTH);
    localparam logic [c_BIT_W-1:0]     c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0]     c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [PRESC_WIDTH-1:0] c_P_ONE    = PRESC_WIDTH'(1);

    tx_state_t               r_state;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic [PRESC_WIDTH-1:0]  r_presc_cnt;
    logic [PRESC_WIDTH-1:0]  r_presc_lat;
    logic                    r_par_bit;
    logic                    r_par_en;
    logic                    r_stop2;
    logic                    r_tx;

    logic [DATA_WIDTH-1:0]   w_fifo_data;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_tick;
    logic                    w_last_stop;
    logic [PRESC_WIDTH-1:0]  w_presc_eff;

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (data_valid),
        .wr_data (p_data),
        .pop     (w_pop),
        .rd_data (w_fifo_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (fifo_count)
    );

    assign w_presc_eff = (prescale == '0) ? c_P_ONE : prescale;
    assign w_tick      = (r_presc_cnt == (r_presc_lat - c_P_ONE));
    assign w_last_stop = !r_stop2 || (r_bit_cnt == c_BIT_ONE);

    // A new frame starts from IDLE, or straight out of the final stop bit.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || ((r_state == STOP) && w_tick && w_last_stop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_presc_cnt <= '0;
            r_presc_lat <= c_P_ONE;
            r_par_bit   <= 1'b0;
            r_par_en    <= 1'b0;
            r_stop2     <= 1'b0;
            r_tx        <= 1'b1;
        end else if (w_pop) begin
            r_state     <= START;
            r_tx        <= 1'b0;
            r_shift     <= w_fifo_data;
            r_par_bit   <= calc_parity(c_MAX_DATA_WIDTH'(w_fifo_data), par_type);
            r_par_en    <= par_en;
            r_stop2     <= stop2;
            r_presc_lat <= w_presc_eff;
            r_presc_cnt <= '0;
            r_bit_cnt   <= '0;
        end else if (r_state != IDLE) begin
            if (!w_tick) begin
                r_presc_cnt <= r_presc_cnt + c_P_ONE;
            end else begin
                r_presc_cnt <= '0;
                case (r_state)
                    START: begin
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= '0;
                    end
                    DATA: begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            if (r_par_en) begin
                                r_state <= PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                        end
                    end
                    PARITY: begin
                        r_state   <= STOP;
                        r_tx      <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                    STOP: begin
                        if (!w_last_stop)
                            r_bit_cnt <= c_BIT_ONE;
                        else
                            r_state <= IDLE;
                        r_tx <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx_out     = r_tx;
    assign busy       = (r_state != IDLE) || !w_empty;
    assign data_ready = !w_full;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_gen.sv
// ============================================================================
// tb_uart_tx_gen : directed bench with a frame scoreboard for uart_tx_gen.
// Revision       : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_gen;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          data_ready;
    logic          par_en;
    logic          par_type;
    logic          stop2;
    logic [PW-1:0] prescale;
    logic          tx_out;
    logic          busy;
    logic [2:0]    fifo_count;

    uart_tx_gen #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (FD),
        .PRESC_WIDTH (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .par_en     (par_en),
        .par_type   (par_type),
        .stop2      (stop2),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          par_en;
        logic          par_type;
        logic          stop2;
        int            p;
    } frame_t;

    frame_t expq[$];
    int     checks      = 0;
    int     failures    = 0;
    int     frames_done = 0;
    logic   saw_full    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input logic [DW-1:0] d, input int p);
        frame_t f;
        f.data     = d;
        f.par_en   = par_en;
        f.par_type = par_type;
        f.stop2    = stop2;
        f.p        = p;
        expq.push_back(f);
    endfunction

    // Serial monitor: decodes each frame clock by clock against the scoreboard.
    initial begin
        frame_t      f;
        logic [15:0] bits;
        int          nbits, idx, cnt, p;
        logic        active;
        active = 1'b0;
        bits   = '0;
        nbits  = 0; idx = 0; cnt = 0; p = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else begin
                if (!active && tx_out === 1'b0) begin
                    checks++;
                    assert (expq.size() > 0) else begin
                        failures++;
                        $error("FAIL unexpected_start observed=start expected=idle");
                    end
                    if (expq.size() > 0) begin
                        f       = expq.pop_front();
                        bits    = '0;
                        bits[0] = 1'b0;
                        for (int i = 0; i < DW; i++)
                            bits[1+i] = f.data[i];
                        nbits = 1 + DW;
                        if (f.par_en) begin
                            bits[nbits] = (^f.data) ^ f.par_type;
                            nbits++;
                        end
                        bits[nbits] = 1'b1;
                        nbits++;
                        if (f.stop2) begin
                            bits[nbits] = 1'b1;
                            nbits++;
                        end
                        p      = f.p;
                        idx    = 0;
                        cnt    = 0;
                        active = 1'b1;
                    end
                end
                if (active) begin
                    checks++;
                    assert (tx_out === bits[idx]) else begin
                        failures++;
                        $error("FAIL frame_bit idx=%0d data=%0h observed=%b expected=%b",
                               idx, f.data, tx_out, bits[idx]);
                    end
                    cnt++;
                    if (cnt == p) begin
                        cnt = 0;
                        idx++;
                        if (idx == nbits) begin
                            active = 1'b0;
                            frames_done++;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input int p, input bit hold);
        bit done;
        done = 1'b0;
        @(negedge clk);
        p_data     = d;
        data_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (data_ready) begin
                push_exp(d, p);
                @(posedge clk);
                done = 1'b1;
            end else begin
                saw_full = 1'b1;
                check("full_count", 32'(fifo_count), FD);
                @(negedge clk);
            end
        end
        if (!done)
            check("send_timeout", 0, 1);
        if (!hold) begin
            #1 data_valid = 1'b0;
        end
    endtask

    // Clocks from the first start bit until busy drops.
    task automatic measure(output int n);
        int guard;
        guard = 0;
        n     = 0;
        @(negedge clk);
        while (tx_out !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_frames(input int target);
        int guard;
        guard = 0;
        while (frames_done < target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        while (busy === 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("frames_done", frames_done, target);
        check("queue_empty", expq.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n;
        int            base;
        logic [DW-1:0] words [6];
        words = '{8'h11, 8'h2E, 8'hC7, 8'h90, 8'h5A, 8'hF3};

        rst = 1'b1; data_valid = 1'b0; p_data = '0;
        par_en = 1'b0; par_type = 1'b0; stop2 = 1'b0; prescale = 8'd4;
        #12;
        check("rst_tx_out", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", data_ready, 1);
        check("rst_count", fifo_count, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("post_rst_tx_out", tx_out, 1);
        check("post_rst_busy", busy, 0);

        // Even parity, one stop bit.
        prescale = 8'd4; par_en = 1'b1; par_type = 1'b0; stop2 = 1'b0;
        send(8'hA5, 4, 0);
        measure(n);
        check("t1_frame_len", n, 44);
        check("t1_busy_low", busy, 0);
        check("t1_frames", frames_done, 1);

        // Odd parity, two stop bits.
        par_type = 1'b1; stop2 = 1'b1;
        send(8'hA5, 4, 0);
        measure(n);
        check("t2_frame_len", n, 48);
        check("t2_frames", frames_done, 2);

        // Prescale 0 acts as 1; two frames must run back to back.
        prescale = 8'd0; par_en = 1'b0; par_type = 1'b0; stop2 = 1'b0;
        send(8'h00, 1, 1);
        send(8'hFF, 1, 0);
        measure(n);
        check("t3_pair_len", n, 20);
        check("t3_frames", frames_done, 4);

        // Six words held on the handshake; FIFO must fill and stall the producer.
        prescale = 8'd2; par_en = 1'b1; par_type = 1'b1; stop2 = 1'b0;
        saw_full = 1'b0;
        base = frames_done;
        for (int i = 0; i < 6; i++)
            send(words[i], 2, (i < 5));
        wait_frames(base + 6);
        check("t4_saw_full", saw_full, 1);
        check("t4_count_zero", fifo_count, 0);

        // Reset in the middle of a data bit with a second word queued.
        prescale = 8'd4; par_en = 1'b0; stop2 = 1'b0;
        send(8'h3C, 4, 1);
        send(8'h55, 4, 0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_tx_out", tx_out, 1);
        check("t5_busy", busy, 0);
        check("t5_count", fifo_count, 0);
        check("t5_ready", data_ready, 1);
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        base = frames_done;
        send(8'h81, 4, 0);
        measure(n);
        check("t5_frame_len", n, 40);
        check("t5_frames", frames_done, base + 1);

        // Prescale change mid-frame only affects the following frame.
        prescale = 8'd4; par_en = 1'b0; stop2 = 1'b0;
        base = frames_done;
        send(8'h55, 4, 0);
        n = 0;
        @(negedge clk);
        for (int g = 0; g < 200 && tx_out !== 1'b0; g++)
            @(negedge clk);
        while (busy === 1'b1 && n < 1000) begin
            n++;
            if (n == 6) begin
                prescale   = 8'd8;
                p_data     = 8'hC3;
                data_valid = 1'b1;
                push_exp(8'hC3, 8);
            end
            if (n == 7)
                data_valid = 1'b0;
            @(negedge clk);
        end
        check("t6_total_len", n, 120);
        wait_frames(base + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
